// File: rtl/onewire_txn_ctrl.sv
// 1-wire transaction sequencer: turns byte-level commands (bus reset, write N, read N)
// into single bit-slot requests for the bit transceiver, moving data LSB first
// between the TX/RX FIFOs and the bus. A watchdog aborts a slot that never completes.
module onewire_txn_ctrl #(
    parameter int unsigned            TIMER_WIDTH    = 19,
    parameter logic [TIMER_WIDTH-1:0] TIMEOUT_CYCLES = 19'd500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_count,
    input  logic       txfifo_empty,
    output logic       txfifo_re,
    input  logic [7:0] txfifo_do,
    input  logic       rxfifo_full,
    output logic       rxfifo_we,
    output logic [7:0] rxfifo_di,
    output logic       bit_req,
    output logic [1:0] bit_op,
    input  logic       bit_ack,
    input  logic       bit_rx,
    output logic       busy,
    output logic       done,
    output logic       presence,
    output logic       error
);

    localparam logic [1:0] OpReset = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRead  = 2'b10;

    localparam logic [1:0] SlotReset  = 2'b00;
    localparam logic [1:0] SlotWrite0 = 2'b01;
    localparam logic [1:0] SlotWrite1 = 2'b10;
    localparam logic [1:0] SlotRead   = 2'b11;

    // Last watchdog value before the slot is declared stalled.
    localparam logic [TIMER_WIDTH-1:0] TimeoutLast = TIMEOUT_CYCLES - TIMER_WIDTH'(1);

    typedef enum logic [3:0] {
        StIdle,
        StRstIssue,
        StFetch,
        StLoad,
        StBitIssue,
        StBitWait,
        StByteEnd,
        StStore,
        StDone,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             op_q;
    logic [7:0]             count_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_idx_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic                   presence_q;
    logic                   error_q;
    logic [1:0]             slot_op;

    // Slot type for the command in flight; stable for the whole slot because
    // shift_q only moves on the edge that samples bit_ack.
    assign slot_op = (op_q == OpReset) ? SlotReset :
                     (op_q == OpRead)  ? SlotRead  :
                     (shift_q[0]       ? SlotWrite1 : SlotWrite0);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OpReset: state_d = StRstIssue;
                        OpWrite: state_d = (cmd_count == 8'd0) ? StDone : StFetch;
                        OpRead:  state_d = (cmd_count == 8'd0) ? StDone : StBitIssue;
                        default: state_d = StError;
                    endcase
                end
            end
            StRstIssue: state_d = StBitWait;
            StFetch:    if (!txfifo_empty) state_d = StLoad;
            StLoad:     state_d = StBitIssue;
            StBitIssue: state_d = StBitWait;
            StBitWait: begin
                if (bit_ack) begin
                    if (op_q == OpReset) begin
                        state_d = bit_rx ? StError : StDone;
                    end else begin
                        state_d = (bit_idx_q == 3'd7) ? StByteEnd : StBitIssue;
                    end
                end else if (timer_q == TimeoutLast) begin
                    state_d = StError;
                end
            end
            StByteEnd: begin
                if (op_q == OpWrite) begin
                    state_d = (count_q <= 8'd1) ? StDone : StFetch;
                end else begin
                    state_d = StStore;
                end
            end
            StStore: begin
                if (!rxfifo_full) state_d = (count_q <= 8'd1) ? StDone : StBitIssue;
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: command latch, shift register, bit/byte counters, watchdog, status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q       <= 2'b00;
            count_q    <= 8'd0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            timer_q    <= '0;
            presence_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        count_q   <= cmd_count;
                        bit_idx_q <= 3'd0;
                        error_q   <= 1'b0;
                    end
                end
                StRstIssue, StBitIssue: timer_q <= '0;
                StLoad: begin
                    shift_q   <= txfifo_do;
                    bit_idx_q <= 3'd0;
                end
                StBitWait: begin
                    timer_q <= timer_q + TIMER_WIDTH'(1);
                    if (bit_ack) begin
                        if (op_q == OpReset) begin
                            presence_q <= ~bit_rx;
                        end else begin
                            // Read fills from the top so the first bit ends up at bit 0.
                            shift_q   <= {(op_q == OpRead) ? bit_rx : 1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                StByteEnd: begin
                    if (op_q == OpWrite && count_q != 8'd0) count_q <= count_q - 8'd1;
                end
                StStore: begin
                    if (!rxfifo_full && count_q != 8'd0) count_q <= count_q - 8'd1;
                end
                StError: error_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Output decode; bit_req is pure state decode so reset drops it immediately.
    always_comb begin
        cmd_ready = 1'b0;
        txfifo_re = 1'b0;
        rxfifo_we = 1'b0;
        rxfifo_di = 8'd0;
        bit_req   = 1'b0;
        bit_op    = 2'b00;
        done      = 1'b0;
        unique case (state_q)
            StIdle:     cmd_ready = ~reset;
            StRstIssue: begin
                bit_req = 1'b1;
                bit_op  = SlotReset;
            end
            StFetch:    txfifo_re = ~txfifo_empty;
            StBitIssue, StBitWait: begin
                bit_req = 1'b1;
                bit_op  = slot_op;
            end
            StStore: begin
                if (!rxfifo_full) begin
                    rxfifo_we = 1'b1;
                    rxfifo_di = shift_q;
                end
            end
            StDone:     done = 1'b1;
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign presence = presence_q;
    assign error    = error_q;

endmodule

// File: tb/tb_onewire_txn_ctrl.sv
// Self-checking bench for onewire_txn_ctrl: vector table, hand-written corner
// sequences and randomized commands against a byte/bit-level reference model.
module tb_onewire_txn_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_count;
    logic       txfifo_empty;
    logic       txfifo_re;
    logic [7:0] txfifo_do;
    logic       rxfifo_full;
    logic       rxfifo_we;
    logic [7:0] rxfifo_di;
    logic       bit_req;
    logic [1:0] bit_op;
    logic       bit_ack;
    logic       bit_rx;
    logic       busy;
    logic       done;
    logic       presence;
    logic       error;

    always #5 clock = ~clock;

    onewire_txn_ctrl #(
        .TIMER_WIDTH   (19),
        .TIMEOUT_CYCLES(19'd16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_count   (cmd_count),
        .txfifo_empty(txfifo_empty),
        .txfifo_re   (txfifo_re),
        .txfifo_do   (txfifo_do),
        .rxfifo_full (rxfifo_full),
        .rxfifo_we   (rxfifo_we),
        .rxfifo_di   (rxfifo_di),
        .bit_req     (bit_req),
        .bit_op      (bit_op),
        .bit_ack     (bit_ack),
        .bit_rx      (bit_rx),
        .busy        (busy),
        .done        (done),
        .presence    (presence),
        .error       (error)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  cnt;
        logic [15:0] tx;
        logic [7:0]  rxb;
        int          ack_dly;
        bit          exp_done;
        bit          exp_err;
        bit          exp_pres;
        int          exp_re;
        logic [7:0]  exp_rx0;
        int          exp_nops;
        logic [1:0]  exp_op0;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_q[$];
    logic       rx_q[$];
    logic [7:0] m_tx[$];
    logic       m_rx[$];
    logic [1:0] obs_ops[$];
    logic [7:0] obs_rx[$];
    int n_re, n_done, n_req_cyc, first_req_cyc, ack_cyc, done_cyc, we_cyc, op_unstable, acks;
    bit exp_presence;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one command and act as FIFOs plus bit transceiver until the controller idles.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] cnt, input int ack_dly,
                           input int empty_until, input int full_until, input int abort_acks);
        int         cyc;
        bit         slot;
        int         cd;
        logic [1:0] slot_op;
        cyc = 0; slot = 0; cd = 0; slot_op = 2'b00;
        obs_ops.delete();
        obs_rx.delete();
        n_re = 0; n_done = 0; n_req_cyc = 0; first_req_cyc = -1; ack_cyc = -1;
        done_cyc = -1; we_cyc = -1; op_unstable = 0; acks = 0;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("error_clear_on_accept", error, 0);
        while (busy && cyc < 2000 && !(abort_acks > 0 && acks >= abort_acks)) begin
            bit_ack      = 1'b0;
            txfifo_empty = (tx_q.size() == 0) || (cyc < empty_until);
            rxfifo_full  = (cyc < full_until);
            #1;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bit_req) begin
                n_req_cyc++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (txfifo_re) begin
                n_re++;
                txfifo_do = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
            end
            if (rxfifo_we) begin
                obs_rx.push_back(rxfifo_di);
                if (we_cyc < 0) we_cyc = cyc;
            end
            if (slot) begin
                if (bit_req && bit_op !== slot_op) op_unstable++;
                if (bit_req) begin
                    if (cd <= 1) begin
                        bit_ack = 1'b1;
                        bit_rx  = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b0;
                        obs_ops.push_back(bit_op);
                        ack_cyc = cyc;
                        acks++;
                        slot = 0;
                    end else begin
                        cd--;
                    end
                end
            end else if (bit_req) begin
                slot    = 1;
                slot_op = bit_op;
                cd      = ack_dly;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bit_ack     = 1'b0;
        rxfifo_full = 1'b0;
        if (abort_acks == 0) chk("cmd_finished", busy, 0);
    endtask

    // Reference model: derive slot sequence, RX bytes and status from the command alone.
    task automatic check_cmd(input string tag, input logic [1:0] op, input logic [7:0] cnt);
        logic [1:0] e_ops[$];
        logic [7:0] e_rx[$];
        logic [7:0] b;
        int         e_re;
        bit         e_done;
        bit         e_err;
        int         bad;
        e_re = 0; e_done = 0; e_err = 0;
        case (op)
            2'b00: begin
                e_ops.push_back(2'b00);
                e_err        = m_rx[0];
                e_done       = !m_rx[0];
                exp_presence = !m_rx[0];
            end
            2'b01: begin
                for (int i = 0; i < int'(cnt); i++)
                    for (int j = 0; j < 8; j++) e_ops.push_back(m_tx[i][j] ? 2'b10 : 2'b01);
                e_re   = int'(cnt);
                e_done = 1;
            end
            2'b10: begin
                for (int i = 0; i < int'(cnt); i++) begin
                    b = 8'h00;
                    for (int j = 0; j < 8; j++) begin
                        e_ops.push_back(2'b11);
                        b = b | (8'(m_rx[8 * i + j]) << j);
                    end
                    e_rx.push_back(b);
                end
                e_done = 1;
            end
            default: e_err = 1;
        endcase
        chk({tag, "_nslots"}, obs_ops.size(), e_ops.size());
        bad = 0;
        for (int i = 0; i < e_ops.size() && i < obs_ops.size(); i++)
            if (obs_ops[i] !== e_ops[i]) bad++;
        chk({tag, "_slot_ops"}, bad, 0);
        chk({tag, "_nbytes_rx"}, obs_rx.size(), e_rx.size());
        bad = 0;
        for (int i = 0; i < e_rx.size() && i < obs_rx.size(); i++)
            if (obs_rx[i] !== e_rx[i]) bad++;
        chk({tag, "_rx_data"}, bad, 0);
        chk({tag, "_txfifo_re"}, n_re, e_re);
        chk({tag, "_done"}, n_done, e_done);
        chk({tag, "_error"}, error, e_err);
        chk({tag, "_presence"}, presence, exp_presence);
        chk({tag, "_op_stable"}, op_unstable, 0);
    endtask

    task automatic stage();
        tx_q = m_tx;
        rx_q = m_rx;
    endtask

    vec_t       tbl[9];
    logic [1:0] lit_ops[16];
    int         w0;
    int         w1;
    logic [1:0] rop;
    logic [7:0] rcnt;
    int         sel;

    initial begin
        tbl[0] = '{2'b00, 8'd0, 16'h0000, 8'h00, 10, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1, 2'b00};
        tbl[1] = '{2'b00, 8'd0, 16'h0000, 8'h01, 3, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1, 2'b00};
        tbl[2] = '{2'b01, 8'd2, 16'h3CA5, 8'h00, 2, 1'b1, 1'b0, 1'b0, 2, 8'h00, 16, 2'b10};
        tbl[3] = '{2'b10, 8'd1, 16'h0000, 8'h4D, 3, 1'b1, 1'b0, 1'b0, 0, 8'h4D, 8, 2'b11};
        tbl[4] = '{2'b01, 8'd0, 16'h0000, 8'h00, 1, 1'b1, 1'b0, 1'b0, 0, 8'h00, 0, 2'b00};
        tbl[5] = '{2'b10, 8'd0, 16'h0000, 8'h00, 1, 1'b1, 1'b0, 1'b0, 0, 8'h00, 0, 2'b00};
        tbl[6] = '{2'b11, 8'd5, 16'h0000, 8'h00, 1, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0, 2'b00};
        tbl[7] = '{2'b00, 8'd0, 16'h0000, 8'h00, 1, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1, 2'b00};
        tbl[8] = '{2'b01, 8'd1, 16'h0001, 8'h00, 2, 1'b1, 1'b0, 1'b1, 1, 8'h00, 8, 2'b10};
        lit_ops = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10,
                    2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 8'd0;
        txfifo_empty = 1'b1; txfifo_do = 8'h00; rxfifo_full = 1'b0;
        bit_ack = 1'b0; bit_rx = 1'b0;
        exp_presence = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs_zero", {cmd_ready, txfifo_re, rxfifo_we, rxfifo_di, bit_req, bit_op,
                                   busy, done, presence, error}, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("ready_after_reset", cmd_ready, 1);

        // Table-driven commands.
        for (int i = 0; i < 9; i++) begin
            m_tx.delete();
            m_rx.delete();
            for (int k = 0; k < int'(tbl[i].cnt) && k < 2; k++)
                m_tx.push_back(k == 0 ? tbl[i].tx[7:0] : tbl[i].tx[15:8]);
            if (tbl[i].op == 2'b00) m_rx.push_back(tbl[i].rxb[0]);
            if (tbl[i].op == 2'b10 && tbl[i].cnt != 8'd0)
                for (int j = 0; j < 8; j++) m_rx.push_back(tbl[i].rxb[j]);
            stage();
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].ack_dly, 0, 0, 0);
            chk($sformatf("tbl%0d_done", i), n_done, tbl[i].exp_done);
            chk($sformatf("tbl%0d_error", i), error, tbl[i].exp_err);
            chk($sformatf("tbl%0d_presence", i), presence, tbl[i].exp_pres);
            chk($sformatf("tbl%0d_txfifo_re", i), n_re, tbl[i].exp_re);
            chk($sformatf("tbl%0d_nslots", i), obs_ops.size(), tbl[i].exp_nops);
            if (tbl[i].exp_nops > 0)
                chk($sformatf("tbl%0d_first_op", i), obs_ops[0], tbl[i].exp_op0);
            if (tbl[i].op == 2'b10 && tbl[i].cnt != 8'd0) begin
                chk($sformatf("tbl%0d_nrx", i), obs_rx.size(), 1);
                chk($sformatf("tbl%0d_rx0", i), obs_rx.size() > 0 ? obs_rx[0] : 8'hxx,
                    tbl[i].exp_rx0);
            end
            if (tbl[i].op == 2'b00) begin
                chk($sformatf("tbl%0d_req_latency", i), first_req_cyc, 0);
                if (tbl[i].exp_done)
                    chk($sformatf("tbl%0d_done_latency", i),
                        (done_cyc - ack_cyc >= 1) && (done_cyc - ack_cyc <= 2), 1);
            end
        end
        exp_presence = tbl[8].exp_pres;

        // Write A5,3C: exact slot-op sequence.
        m_tx = '{8'hA5, 8'h3C};
        m_rx.delete();
        stage();
        run_cmd(2'b01, 8'd2, 1, 0, 0, 0);
        chk("wr2_nslots", obs_ops.size(), 16);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 16 && i < obs_ops.size(); i++)
                if (obs_ops[i] !== lit_ops[i]) bad++;
            chk("wr2_op_sequence", bad, 0);
        end
        check_cmd("wr2", 2'b01, 8'd2);

        // RX FIFO full for 5 extra cycles delays the store by exactly 5 cycles.
        m_tx.delete();
        m_rx = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        stage();
        run_cmd(2'b10, 8'd1, 1, 0, 0, 0);
        w0 = we_cyc;
        check_cmd("rd_base", 2'b10, 8'd1);
        stage();
        run_cmd(2'b10, 8'd1, 1, 0, w0 + 5, 0);
        w1 = we_cyc;
        chk("rd_full_delay", w1 - w0, 5);
        check_cmd("rd_full", 2'b10, 8'd1);

        // TX FIFO empty for 20 cycles: no slot until data, no error.
        m_tx = '{8'h5A};
        m_rx.delete();
        stage();
        run_cmd(2'b01, 8'd1, 2, 20, 0, 0);
        chk("empty_wait_no_early_req", first_req_cyc >= 20, 1);
        check_cmd("empty_wait", 2'b01, 8'd1);

        // Transceiver never acks: watchdog fires after the timeout.
        m_tx.delete();
        m_rx.delete();
        stage();
        run_cmd(2'b10, 8'd1, 100000, 0, 0, 0);
        chk("timeout_error", error, 1);
        chk("timeout_no_done", n_done, 0);
        chk("timeout_req_len", (n_req_cyc >= 16) && (n_req_cyc <= 18), 1);
        chk("timeout_req_dropped", bit_req, 0);
        chk("timeout_idle", busy, 0);

        // Reset in the middle of a byte.
        m_tx = '{8'hC3};
        m_rx.delete();
        stage();
        run_cmd(2'b01, 8'd1, 2, 0, 0, 3);
        chk("midbyte_req_held", bit_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midbyte_reset_outputs_zero", {cmd_ready, txfifo_re, rxfifo_we, rxfifo_di, bit_req,
                                           bit_op, busy, done, presence, error}, 0);
        exp_presence = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        m_tx.delete();
        m_rx = '{1'b0};
        stage();
        run_cmd(2'b00, 8'd0, 4, 0, 0, 0);
        check_cmd("after_reset", 2'b00, 8'd0);

        // Randomized commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 9);
            rop  = (sel < 2) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            rcnt = 8'($urandom_range(0, 3));
            m_tx.delete();
            m_rx.delete();
            if (rop == 2'b01)
                for (int i = 0; i < int'(rcnt); i++) m_tx.push_back(8'($urandom_range(0, 255)));
            if (rop == 2'b00) m_rx.push_back(1'($urandom_range(0, 1)));
            if (rop == 2'b10)
                for (int i = 0; i < 8 * int'(rcnt); i++) m_rx.push_back(1'($urandom_range(0, 1)));
            stage();
            run_cmd(rop, rcnt, $urandom_range(1, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), 0);
            check_cmd($sformatf("rnd%0d", n), rop, rcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
